pkt_tx_framer: RTL
==================

PKT_TX_FRAMER -- requirements
Module: pkt_tx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the payload bits per beat; it must be a multiple of 8.
REQ-002 SHALL have parameter IFG_CYCLES, default 2, meaning the idle cycles inserted after each packet; legal range is 0..255.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, meaning the width of the statistics counters.
REQ-004 SHALL use one clock, clk, and an asynchronous active-low reset, reset_n, as already decided.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 enable  in  1  permits the start of new packets.
REQ-008 clear_counters  in  1  synchronous clear of the statistics counters.
REQ-009 fifo_dout  in  DATA_WIDTH+DATA_WIDTH/8+1  word from the upstream fall-through FIFO, packed {last, keep, data}; the word is valid whenever fifo_empty is low.
REQ-010 fifo_empty  in  1  upstream FIFO empty flag.
REQ-011 fifo_rd_en  out  1  pops the current upstream word.
REQ-012 m_axis_tdata  out  DATA_WIDTH  output payload.
REQ-013 m_axis_tkeep  out  DATA_WIDTH/8  output byte enables.
REQ-014 m_axis_tlast  out  1  marks the last beat of a packet.
REQ-015 m_axis_tvalid  out  1  output beat valid.
REQ-016 m_axis_tready  in  1  downstream accepts the beat.
REQ-017 busy  out  1  high when the state is not IDLE.
REQ-018 pkt_count  out  CNT_WIDTH  number of packets sent.
REQ-019 byte_count  out  CNT_WIDTH  number of bytes sent.

Function
REQ-020 SHALL implement the states IDLE, SEND and GAP.
REQ-021 IDLE -> SEND on a cycle with enable=1 and fifo_empty=0; otherwise the FSM SHALL remain in IDLE.
REQ-022 In SEND, outputs SHALL be combinational pass-through: m_axis_tvalid=!fifo_empty; tdata, tkeep and tlast taken from the fifo_dout fields.
REQ-023 Outside SEND, m_axis_tvalid and fifo_rd_en SHALL be 0 and tdata/tkeep/tlast SHALL be 0.
REQ-024 fifo_rd_en SHALL equal m_axis_tvalid & m_axis_tready; a beat counts as accepted only in that cycle.
REQ-025 Once tvalid=1, tdata/tkeep/tlast SHALL stay stable until the beat is accepted; an upstream FIFO empty mid-packet SHALL drop tvalid without leaving SEND.
REQ-026 On an accepted beat with tlast=1: if IFG_CYCLES=0, go to IDLE; otherwise go to GAP with the gap counter loaded with IFG_CYCLES.
REQ-027 In GAP, the gap counter SHALL decrement every cycle; on the cycle the counter equals 1, the FSM SHALL go to IDLE, giving exactly IFG_CYCLES cycles in GAP.
REQ-028 enable deasserted in SEND or GAP SHALL NOT abort the packet or the gap; it is only checked in IDLE.
REQ-029 pkt_count SHALL increment by 1 on each accepted beat with tlast=1.
REQ-030 byte_count SHALL add popcount(tkeep) on each accepted beat; a beat with tkeep=0 adds 0.
REQ-031 Both counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-032 clear_counters=1 SHALL zero both counters on the next edge and takes priority over a simultaneous increment.
REQ-033 Minimum packet-to-packet spacing: last beat accepted at cycle t -> next first beat presented no earlier than cycle t+IFG_CYCLES+2.

Reset
REQ-034 reset_n low SHALL asynchronously force state=IDLE, gap counter=0, pkt_count=0 and byte_count=0; all outputs SHALL then read 0.
REQ-035 Reset asserted mid-packet SHALL abandon the packet; remaining upstream words are framed as a new packet after reset_n is released.
REQ-036 Reset release SHALL be synchronous to clk, and the first transition out of IDLE occurs no earlier than the first edge after release.

Verification
REQ-037 Scenario "basic": IFG_CYCLES=2, 3-beat packet with tkeep FF, FF, 0F, tready=1 -> beats on 3 consecutive cycles, 2 GAP cycles, pkt_count=1, byte_count=20.
REQ-038 Scenario "backpressure": tready toggling 1,0,0,1 during the packet -> no beat lost or duplicated, fifo_rd_en only when tready=1, data stable while stalled.
REQ-039 Scenario "FIFO underrun": fifo_empty=1 for 3 cycles mid-packet -> tvalid=0 for those cycles, busy=1, packet completes correctly afterwards.
REQ-040 Scenario "IFG=0 and enable": IFG_CYCLES=0 with back-to-back packets -> exactly 1 IDLE cycle between tlast and the next first beat; enable dropped mid-packet -> packet finishes, no new start.
REQ-041 Scenario "clear collision": clear_counters asserted in the same cycle as a tlast beat -> both counters read 0 on the next cycle.
REQ-042 Scenario "reset mid-packet": reset_n low during beat 2 of 4 -> outputs 0 immediately, counters 0, FSM in IDLE.

Source files
------------

// File: rtl/pkt_tx_framer.sv
// Transmit framer: drains a fall-through FIFO onto an AXI-Stream master, inserts an
// inter-frame gap after every packet and keeps packet/byte statistics.
module pkt_tx_framer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned IFG_CYCLES = 2,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic                             clear_counters,
    input  logic [DATA_WIDTH+DATA_WIDTH/8:0] fifo_dout,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]          m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             busy,
    output logic [CNT_WIDTH-1:0]             pkt_count,
    output logic [CNT_WIDTH-1:0]             byte_count
);

    localparam int unsigned KEEP_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           gap_q, gap_d;
    logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0] byte_count_q, byte_count_d;
    logic                 beat_acc;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [KEEP_W-1:0] v);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            n = n + CNT_WIDTH'(v[i]);
        end
        return n;
    endfunction

    // Payload path is a pure pass-through of the FIFO head while sending, so
    // stability under backpressure comes from the FIFO holding its head word.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        if (state_q == SEND) begin
            m_axis_tvalid = !fifo_empty;
            m_axis_tdata  = fifo_dout[DATA_WIDTH-1:0];
            m_axis_tkeep  = fifo_dout[DATA_WIDTH +: KEEP_W];
            m_axis_tlast  = fifo_dout[DATA_WIDTH+KEEP_W];
        end
    end

    assign beat_acc   = m_axis_tvalid & m_axis_tready;
    assign fifo_rd_en = beat_acc;
    assign busy       = (state_q != IDLE);
    assign pkt_count  = pkt_count_q;
    assign byte_count = byte_count_q;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beat_acc && m_axis_tlast) begin
                    if (IFG_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = 8'(IFG_CYCLES);
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over a same-cycle increment.
    always_comb begin
        pkt_count_d  = pkt_count_q;
        byte_count_d = byte_count_q;
        if (clear_counters) begin
            pkt_count_d  = '0;
            byte_count_d = '0;
        end else if (beat_acc) begin
            pkt_count_d  = pkt_count_q + CNT_WIDTH'(m_axis_tlast);
            byte_count_d = byte_count_q + popcount(m_axis_tkeep);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gap_q        <= '0;
            pkt_count_q  <= '0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            pkt_count_q  <= pkt_count_d;
            byte_count_q <= byte_count_d;
        end
    end

endmodule
